// File: rtl/avr_irq_ctrl_if.sv
// ============================================================================
// Module   : avr_irq_ctrl_if
// Purpose  : Bundles the core-facing signals of the AVR interrupt controller:
//            the I/O-mapped register bus and the iflag/ivect/ack handshake.
// Signals  : io_a     6  core I/O address
//            io_re    1  core I/O read strobe
//            io_we    1  core I/O write strobe
//            io_do    8  write data from the core
//            io_di    8  read data to the core (0 when not selected/reading)
//            iflag    1  interrupt request to the core
//            ivect    2  vector presented to the core
//            ack_stb  1  one-cycle acknowledge pulse from the core
//            ack_vect 2  vector being acknowledged
// Modports : master = core side, slave = interrupt controller side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avr_irq_ctrl_if;
    logic [5:0] io_a;
    logic       io_re;
    logic       io_we;
    logic [7:0] io_do;
    logic [7:0] io_di;
    logic       iflag;
    logic [1:0] ivect;
    logic       ack_stb;
    logic [1:0] ack_vect;

    modport master (
        output io_a, io_re, io_we, io_do, ack_stb, ack_vect,
        input  io_di, iflag, ivect
    );

    modport slave (
        input  io_a, io_re, io_we, io_do, ack_stb, ack_vect,
        output io_di, iflag, ivect
    );
endinterface

`default_nettype wire

// File: rtl/avr_irq_ctrl.sv
// ============================================================================
// Module   : avr_irq_ctrl
// Purpose  : Registered interrupt controller between four peripheral IRQ
//            lines and the avr_core iflag/ivect inputs. Latches edge requests,
//            follows level requests, masks per source, arbitrates, and holds
//            the presented vector until the core acknowledges it.
// Ports    : clk     1  system clock
//            rst_n   1  asynchronous active-low reset
//            irq_in  4  raw request lines (bit 0 = highest fixed priority)
//            bus        avr_irq_ctrl_if.slave (I/O bus + iflag/ivect/ack)
// Registers: IO_BASE+0 IPR (pending, W1C for edge bits)
//            IO_BASE+1 IMR (enable mask)
//            IO_BASE+2 ITR (1 = rising edge, 0 = level)
//            IO_BASE+3 ISR (RO: [7] in REQ, [5:4] last vector, [1:0] ivect)
// Options  : AVR_IRQ_RR_EN - when defined, rotating priority starting after
//            the last acknowledged vector; otherwise fixed 0 > 1 > 2 > 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avr_irq_ctrl #(
    parameter logic [5:0] IO_BASE = 6'h24,
    parameter int         HOLDOFF = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     irq_in,
    avr_irq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] irq_prev_q;
    logic [3:0] pend_q, pend_d;
    logic [3:0] imr_q, imr_d;
    logic [3:0] itr_q, itr_d;
    logic [1:0] last_q, last_d;
    logic [1:0] ivect_q, ivect_d;
    logic       iflag_q;

    logic [5:0] w_off;
    logic       w_sel;
    logic       w_wr;
    logic [3:0] w_elig;
    logic [1:0] w_win;
    logic       w_ack_ok;
    logic [3:0] w_rise;
    logic [3:0] w_w1c;
    logic [3:0] w_ack_clr;
    logic [3:0] w_mode_drop;
    logic [7:0] w_rdata;
    logic       w_unused;

    // Offset wraps to a large value for addresses below IO_BASE, so a single
    // unsigned compare selects the four-register window.
    assign w_off = bus.io_a - IO_BASE;
    assign w_sel = (w_off < 6'd4);
    assign w_wr  = bus.io_we & w_sel;

    assign w_unused = &{1'b0, bus.io_do[7:4]};

    assign w_elig   = pend_q & imr_q;
    assign w_ack_ok = (state_q == S_REQ) && bus.ack_stb && (bus.ack_vect == ivect_q);

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    assign w_rise      = irq_in & ~irq_prev_q;
    assign w_w1c       = (w_wr && (w_off == 6'd0)) ? bus.io_do[3:0] : 4'h0;
    assign w_ack_clr   = w_ack_ok ? (4'b0001 << ivect_q) : 4'h0;
    // Bits switched from edge to level lose their latched edge immediately.
    assign w_mode_drop = (w_wr && (w_off == 6'd2)) ? (itr_q & ~bus.io_do[3:0]) : 4'h0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
        // Edge mode: a new rising edge beats any clear arriving the same cycle.
        assign pend_d[gi] = itr_q[gi]
            ? (~w_mode_drop[gi] & (w_rise[gi] | (pend_q[gi] & ~w_w1c[gi] & ~w_ack_clr[gi])))
            : irq_in[gi];
    end

    always_comb begin
        imr_d = imr_q;
        itr_d = itr_q;
        if (w_wr && (w_off == 6'd1)) imr_d = bus.io_do[3:0];
        if (w_wr && (w_off == 6'd2)) itr_d = bus.io_do[3:0];
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef AVR_IRQ_RR_EN
    logic [1:0] rr_ptr_q;
    logic [1:0] w_idx;

    // Scan from the far end back towards the pointer so the source closest
    // to the pointer (in wrap order) is the last, winning assignment.
    always_comb begin
        w_win = 2'd0;
        w_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = rr_ptr_q + 2'(k);
            if (w_elig[w_idx]) w_win = w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else if (w_ack_ok) begin
            rr_ptr_q <= ivect_q + 2'd1;
        end
    end
`else
    always_comb begin
        w_win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_elig[k]) w_win = 2'(k);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ivect_d    = ivect_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|w_elig) begin
                    ivect_d = w_win;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The presented vector is frozen; only an ack or loss of
                // eligibility of that very source moves the FSM on.
                if (w_ack_ok) begin
                    last_d     = ivect_q;
                    hold_cnt_d = 4'd0;
                    state_d    = S_HOLD;
                end else if (!w_elig[ivect_q]) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= 4'd0;
            irq_prev_q <= 4'h0;
            pend_q     <= 4'h0;
            imr_q      <= 4'h0;
            itr_q      <= 4'h0;
            last_q     <= 2'd0;
            ivect_q    <= 2'd0;
            iflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            irq_prev_q <= irq_in;
            pend_q     <= pend_d;
            imr_q      <= imr_d;
            itr_q      <= itr_d;
            last_q     <= last_d;
            ivect_q    <= ivect_d;
            iflag_q    <= (state_d == S_REQ);
        end
    end

    // ------------------------------------------------------------------
    // Register read path (drives a wired-OR bus, so idle value is zero)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 8'h00;
        if (bus.io_re && w_sel) begin
            case (w_off)
                6'd0:    w_rdata = {4'h0, pend_q};
                6'd1:    w_rdata = {4'h0, imr_q};
                6'd2:    w_rdata = {4'h0, itr_q};
                6'd3:    w_rdata = {(state_q == S_REQ), 1'b0, last_q, 2'b00, ivect_q};
                default: w_rdata = 8'h00;
            endcase
        end
    end

    assign bus.io_di = w_rdata;
    assign bus.iflag = iflag_q;
    assign bus.ivect = ivect_q;

endmodule

`default_nettype wire

// File: tb/tb_avr_irq_ctrl.sv
// ============================================================================
// Module   : tb_avr_irq_ctrl
// Purpose  : Self-checking bench for avr_irq_ctrl. Directed scenarios from the
//            controller's behaviour followed by a randomized run, all checked
//            against a behavioural model of pending flags, registers and the
//            request/holdoff sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avr_irq_ctrl;

    localparam logic [5:0] IO_BASE = 6'h24;
    localparam int         HOLDOFF = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_in = 4'h0;

    avr_irq_ctrl_if bus ();

    avr_irq_ctrl #(
        .IO_BASE (IO_BASE),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model state ----------------
    bit [3:0] m_pend, m_imr, m_itr, m_prev;
    bit [1:0] m_vect, m_last, m_ptr;
    int       m_phase;
    int       m_hold_left;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pend = 0; m_imr = 0; m_itr = 0; m_prev = 0;
        m_vect = 0; m_last = 0; m_ptr = 0;
        m_phase = PH_IDLE; m_hold_left = 0;
    endtask

    function automatic bit [1:0] pick(input bit [3:0] e, input bit [1:0] start);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(start) + k) % 4;
            if (e[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    function automatic logic [7:0] m_read(input logic [5:0] a);
        int off;
        off = int'(a) - int'(IO_BASE);
        if (off == 0) return {4'h0, m_pend};
        if (off == 1) return {4'h0, m_imr};
        if (off == 2) return {4'h0, m_itr};
        if (off == 3) return {(m_phase == PH_REQ), 1'b0, m_last, 2'b00, m_vect};
        return 8'h00;
    endfunction

    // One clock edge of the reference behaviour, using the inputs that were
    // stable before that edge.
    task automatic model_edge(input bit [3:0] irq, input logic [5:0] a, input bit we,
                              input bit [7:0] d, input bit ack, input bit [1:0] av);
        int       off;
        bit       wr;
        bit [3:0] elig;
        bit       accepted;
        bit [1:0] old_v;
        bit [3:0] np;
        bit [1:0] start;
        off      = int'(a) - int'(IO_BASE);
        wr       = we && (off >= 0) && (off <= 3);
        elig     = m_pend & m_imr;
        accepted = 1'b0;
        old_v    = m_vect;
`ifdef AVR_IRQ_RR_EN
        start = m_ptr;
`else
        start = 2'd0;
`endif
        if (m_phase == PH_IDLE) begin
            if (elig != 0) begin
                m_vect  = pick(elig, start);
                m_phase = PH_REQ;
            end
        end else if (m_phase == PH_REQ) begin
            if (ack && av == m_vect) begin
                accepted    = 1'b1;
                m_last      = m_vect;
                m_ptr       = m_vect + 2'd1;
                m_phase     = PH_HOLD;
                m_hold_left = HOLDOFF;
            end else if (!elig[m_vect]) begin
                m_phase = PH_IDLE;
            end
        end else begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = PH_IDLE;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_itr[i]) begin
                if (wr && off == 2 && !d[i])                           np[i] = 1'b0;
                else if (irq[i] && !m_prev[i])                         np[i] = 1'b1;
                else if ((wr && off == 0 && d[i]) || (accepted && int'(old_v) == i)) np[i] = 1'b0;
                else                                                    np[i] = m_pend[i];
            end else begin
                np[i] = irq[i];
            end
        end
        m_pend = np;
        if (wr && off == 1) m_imr = d[3:0];
        if (wr && off == 2) m_itr = d[3:0];
        m_prev = irq;
    endtask

    // Starts and ends at a falling edge: drive, check reads, clock, check outputs.
    task automatic cyc(input logic [3:0] irq, input logic [5:0] a, input logic re, input logic we,
                       input logic [7:0] d, input logic ack, input logic [1:0] av);
        irq_in       = irq;
        bus.io_a     = a;
        bus.io_re    = re;
        bus.io_we    = we;
        bus.io_do    = d;
        bus.ack_stb  = ack;
        bus.ack_vect = av;
        #1;
        if (re) chk("io_di", bus.io_di, m_read(a));
        @(posedge clk);
        model_edge(irq, a, we, d, ack, av);
        @(negedge clk);
        chk("iflag", {7'b0, bus.iflag}, {7'b0, (m_phase == PH_REQ)});
        chk("ivect", {6'b0, bus.ivect}, {6'b0, m_vect});
    endtask

    task automatic idle(input logic [3:0] irq);
        cyc(irq, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
    endtask

    task automatic wr(input logic [3:0] irq, input int off, input logic [7:0] d);
        cyc(irq, 6'(int'(IO_BASE) + off), 1'b0, 1'b1, d, 1'b0, 2'd0);
    endtask

    task automatic ackc(input logic [3:0] irq, input logic [1:0] v);
        cyc(irq, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, v);
    endtask

    task automatic rd_expect(input string tag, input logic [5:0] a, input logic [7:0] exp);
        bus.io_a  = a;
        bus.io_re = 1'b1;
        bus.io_we = 1'b0;
        #1;
        chk(tag, bus.io_di, exp);
        bus.io_re = 1'b0;
    endtask

    initial begin
        bus.io_a = 0; bus.io_re = 0; bus.io_we = 0; bus.io_do = 0;
        bus.ack_stb = 0; bus.ack_vect = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_iflag", {7'b0, bus.iflag}, 8'h00);
        chk("rst_ivect", {6'b0, bus.ivect}, 8'h00);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) rd_expect("rst_reg", IO_BASE + 6'(r), 8'h00);

        // Level, fixed priority
        wr(4'h0, 1, 8'h0F);
        idle(4'b1010);
        chk("lvl_lat_iflag", {7'b0, bus.iflag}, 8'h00);
        idle(4'b1010);
        chk("lvl_iflag", {7'b0, bus.iflag}, 8'h01);
        chk("lvl_ivect", {6'b0, bus.ivect}, 8'h01);
        ackc(4'b1010, 2'd1);
        chk("lvl_ack_iflag", {7'b0, bus.iflag}, 8'h00);
        idle(4'b1010);
        idle(4'b1010);
        chk("lvl_hold_iflag", {7'b0, bus.iflag}, 8'h00);
        idle(4'b1010);
        chk("lvl_rereq_iflag", {7'b0, bus.iflag}, 8'h01);
        chk("lvl_rereq_ivect", {6'b0, bus.ivect}, 8'h01);
        idle(4'h0);
        idle(4'h0);
        idle(4'h0);

        // Edge latch
        wr(4'h0, 2, 8'h04);
        wr(4'h0, 1, 8'h04);
        idle(4'b0100);
        idle(4'b0000);
        rd_expect("edge_ipr", IO_BASE, 8'h04);
        chk("edge_ivect", {6'b0, bus.ivect}, 8'h02);
        ackc(4'h0, 2'd2);
        rd_expect("edge_ipr_clr", IO_BASE, 8'h00);
        for (int i = 0; i < 4; i++) begin
            idle(4'h0);
            chk("edge_quiet", {7'b0, bus.iflag}, 8'h00);
        end

        // Mask and withdraw
        wr(4'h0, 2, 8'h00);
        wr(4'b1000, 1, 8'h08);
        idle(4'b1000);
        chk("mask_req", {7'b0, bus.iflag}, 8'h01);
        wr(4'b1000, 1, 8'h00);
        idle(4'b1000);
        chk("mask_withdraw", {7'b0, bus.iflag}, 8'h00);
        rd_expect("mask_isr", IO_BASE + 6'd3, 8'h23);
        idle(4'h0);

        // Wrong ack and bus idle
        wr(4'b0001, 1, 8'h01);
        idle(4'b0001);
        ackc(4'b0001, 2'd2);
        chk("wrong_ack_iflag", {7'b0, bus.iflag}, 8'h01);
        rd_expect("wrong_ack_isr", IO_BASE + 6'd3, 8'hA0);
        rd_expect("bus_other_addr", 6'h20, 8'h00);
        bus.io_a = IO_BASE;
        #1;
        chk("bus_no_re", bus.io_di, 8'h00);
        ackc(4'b0001, 2'd0);
        wr(4'h0, 1, 8'h00);
        repeat (4) idle(4'h0);

        // Simultaneous edge and W1C: the set wins
        wr(4'h0, 2, 8'h01);
        idle(4'h0);
        wr(4'b0001, 0, 8'h01);
        rd_expect("sim_set_wins", IO_BASE, 8'h01);
        wr(4'b0001, 0, 8'h01);
        rd_expect("w1c_clears", IO_BASE, 8'h00);

        // Reset mid-request
        wr(4'h0, 1, 8'h01);
        idle(4'b0001);
        idle(4'b0001);
        chk("rst_pre_req", {7'b0, bus.iflag}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_iflag", {7'b0, bus.iflag}, 8'h00);
        m_reset();
        irq_in = 4'h0;
        bus.ack_stb = 0; bus.io_we = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) rd_expect("rst_mid_reg", IO_BASE + 6'(r), 8'h00);

`ifdef AVR_IRQ_RR_EN
        // Rotating priority
        wr(4'h0, 2, 8'h0F);
        wr(4'h0, 1, 8'h0F);
        idle(4'hF);
        idle(4'h0);
        chk("rr_first", {6'b0, bus.ivect}, 8'h00);
        ackc(4'h0, 2'd0);
        repeat (3) idle(4'h0);
        chk("rr_second", {6'b0, bus.ivect}, 8'h01);
        ackc(4'h0, 2'd1);
        idle(4'b0101);
        idle(4'h0);
        idle(4'h0);
        chk("rr_third", {6'b0, bus.ivect}, 8'h02);
        ackc(4'h0, 2'd2);
        repeat (3) idle(4'h0);
        chk("rr_fourth", {6'b0, bus.ivect}, 8'h03);
        ackc(4'h0, 2'd3);
        repeat (3) idle(4'h0);
`endif

        // Randomized run against the model
        begin
            logic [3:0] irq;
            irq = 4'h0;
            for (int n = 0; n < 600; n++) begin
                int         op;
                logic [5:0] a;
                if ($urandom_range(0, 2) == 0) irq = 4'($urandom);
                a  = ($urandom_range(0, 3) != 0) ? IO_BASE + 6'($urandom_range(0, 3)) : 6'($urandom);
                op = $urandom_range(0, 9);
                if (op <= 1)
                    cyc(irq, a, 1'($urandom), 1'b1, 8'($urandom), 1'b0, 2'd0);
                else if (op <= 4)
                    cyc(irq, a, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
                else if (op <= 6)
                    cyc(irq, a, 1'b1, 1'b0, 8'h00, 1'b1,
                        ($urandom_range(0, 3) != 0) ? m_vect : 2'($urandom));
                else
                    idle(irq);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
